// File: rtl/gumnut_exec_stage.sv
// Gumnut execute/write-back stage: single-cycle ALU, serial 1-bit/cycle shifter,
// Z/C flags with a shadow copy, and a one-cycle write-back strobe to the register bank.
module gumnut_exec_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clkg,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             is_shift_i,
    input  logic [2:0]       func_i,
    input  logic             use_imm_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rs2_val_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [2:0]       count_i,
    input  logic [AW-1:0]    rd_i,
    input  logic             flag_save_i,
    input  logic             flag_restore_i,
    output logic             busy_o,
    output logic             we_o,
    output logic [AW-1:0]    rd_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             z_o,
    output logic             c_o
);
    localparam int unsigned CW = 3;
    localparam int unsigned SW = WIDTH + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [1:0]       sfn_q, sfn_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    srd_q, srd_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             busy_q, busy_d;
    logic             we_q, we_d;
    logic             z_q, z_d, c_q, c_d;
    logic             zs_q, zs_d, cs_q, cs_d;

    logic [WIDTH-1:0] op_b;
    logic [SW-1:0]    alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH-1:0] step_res;
    logic             step_c;
    logic             wb;
    logic [WIDTH-1:0] wb_dat;
    logic             wb_carry;
    logic [AW-1:0]    wb_rd;

    // Single-cycle ALU; arithmetic carried one bit wide so bit WIDTH is carry/borrow
    always_comb begin
        op_b    = use_imm_i ? imm_i : rs2_val_i;
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (func_i)
            3'd0: alu_sum = {1'b0, rs_val_i} + {1'b0, op_b};
            3'd1: alu_sum = {1'b0, rs_val_i} + {1'b0, op_b} + SW'(c_q);
            3'd2: alu_sum = {1'b0, rs_val_i} - {1'b0, op_b};
            3'd3: alu_sum = {1'b0, rs_val_i} - {1'b0, op_b} - SW'(c_q);
            default: alu_sum = '0;
        endcase
        case (func_i)
            3'd4:    alu_res = rs_val_i & op_b;
            3'd5:    alu_res = rs_val_i | op_b;
            3'd6:    alu_res = rs_val_i ^ op_b;
            3'd7:    alu_res = rs_val_i & ~op_b;
            default: begin
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
            end
        endcase
    end

    // One serial shift step; carry is the bit that leaves the register
    always_comb begin
        step_res = sh_q;
        step_c   = 1'b0;
        case (sfn_q)
            2'd0: begin step_res = {sh_q[WIDTH-2:0], 1'b0};         step_c = sh_q[WIDTH-1]; end
            2'd1: begin step_res = {1'b0, sh_q[WIDTH-1:1]};         step_c = sh_q[0];       end
            2'd2: begin step_res = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; step_c = sh_q[WIDTH-1]; end
            default: begin step_res = {sh_q[0], sh_q[WIDTH-1:1]};   step_c = sh_q[0];       end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        sfn_d    = sfn_q;
        cnt_d    = cnt_q;
        srd_d    = srd_q;
        rd_d     = rd_q;
        dat_d    = dat_q;
        busy_d   = busy_q;
        we_d     = 1'b0;
        z_d      = z_q;
        c_d      = c_q;
        zs_d     = zs_q;
        cs_d     = cs_q;
        wb       = 1'b0;
        wb_dat   = '0;
        wb_carry = 1'b0;
        wb_rd    = '0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (is_shift_i && count_i != '0) begin
                        state_d = SHIFT;
                        sh_d    = rs_val_i;
                        sfn_d   = func_i[2] ? 2'd0 : func_i[1:0];
                        cnt_d   = count_i;
                        srd_d   = rd_i;
                        busy_d  = 1'b1;
                    end else begin
                        wb       = 1'b1;
                        wb_dat   = is_shift_i ? rs_val_i : alu_res;
                        wb_carry = is_shift_i ? c_q : alu_c;
                        wb_rd    = rd_i;
                    end
                end
            end
            SHIFT: begin
                sh_d  = step_res;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    wb       = 1'b1;
                    wb_dat   = step_res;
                    wb_carry = step_c;
                    wb_rd    = srd_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // r0 is hardwired zero: flags still update, but no write strobe
        if (wb) begin
            dat_d = wb_dat;
            rd_d  = wb_rd;
            we_d  = (wb_rd != '0);
            z_d   = (wb_dat == '0);
            c_d   = wb_carry;
        end

        if (flag_save_i) begin
            zs_d = z_q;
            cs_d = c_q;
        end
        if (flag_restore_i) begin
            z_d = zs_q;
            c_d = cs_q;
        end
    end

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            sfn_q   <= '0;
            cnt_q   <= '0;
            srd_q   <= '0;
            rd_q    <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            zs_q    <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            sfn_q   <= sfn_d;
            cnt_q   <= cnt_d;
            srd_q   <= srd_d;
            rd_q    <= rd_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            z_q     <= z_d;
            c_q     <= c_d;
            zs_q    <= zs_d;
            cs_q    <= cs_d;
        end
    end

    assign busy_o = busy_q;
    assign we_o   = we_q;
    assign rd_o   = rd_q;
    assign dat_o  = dat_q;
    assign z_o    = z_q;
    assign c_o    = c_q;

endmodule

// File: tb/tb_gumnut_exec_stage.sv
// Randomized self-checking bench for gumnut_exec_stage against an arithmetic reference model.
module tb_gumnut_exec_stage;
    logic       clkg = 1'b0;
    logic       rst  = 1'b1;
    logic       valid_i = 1'b0, is_shift_i = 1'b0, use_imm_i = 1'b0;
    logic [2:0] func_i = '0, count_i = '0, rd_i = '0;
    logic [7:0] rs_val_i = '0, rs2_val_i = '0, imm_i = '0;
    logic       flag_save_i = 1'b0, flag_restore_i = 1'b0;
    logic       busy_o, we_o, z_o, c_o;
    logic [2:0] rd_o;
    logic [7:0] dat_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_z = 0, m_c = 0, s_z = 0, s_c = 0;

    gumnut_exec_stage #(.WIDTH(8), .AW(3)) dut (
        .clkg(clkg), .rst(rst), .valid_i(valid_i), .is_shift_i(is_shift_i),
        .func_i(func_i), .use_imm_i(use_imm_i), .rs_val_i(rs_val_i),
        .rs2_val_i(rs2_val_i), .imm_i(imm_i), .count_i(count_i), .rd_i(rd_i),
        .flag_save_i(flag_save_i), .flag_restore_i(flag_restore_i),
        .busy_o(busy_o), .we_o(we_o), .rd_o(rd_o), .dat_o(dat_o),
        .z_o(z_o), .c_o(c_o)
    );

    always #5 clkg = ~clkg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Whole-operation result from the instruction's definition, not bit-serial stepping
    function automatic void ref_calc(input bit sh, input bit [2:0] f, input int a, input int b,
                                     input int n, input bit cin, output int r, output bit co);
        int t;
        int g;
        co = 0;
        r  = 0;
        if (!sh) begin
            case (f)
                3'd0: begin t = a + b;       r = t & 255; co = (t > 255); end
                3'd1: begin t = a + b + cin; r = t & 255; co = (t > 255); end
                3'd2: begin t = a - b;       r = t & 255; co = (t < 0);   end
                3'd3: begin t = a - b - cin; r = t & 255; co = (t < 0);   end
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = a ^ b;
                default: r = a & ~b & 255;
            endcase
        end else if (n == 0) begin
            r  = a;
            co = cin;
        end else begin
            g = (f > 3) ? 0 : int'(f);
            case (g)
                0: begin r = (a << n) & 255;                 co = ((a >> (8 - n)) & 1) != 0; end
                1: begin r = a >> n;                         co = ((a >> (n - 1)) & 1) != 0; end
                2: begin r = ((a << n) | (a >> (8 - n))) & 255; co = (r & 1) != 0;          end
                default: begin r = ((a >> n) | (a << (8 - n))) & 255; co = ((r >> 7) & 1) != 0; end
            endcase
        end
    endfunction

    // Called at a negedge: drives one cycle of inputs, waits for the result, checks it
    task automatic run_op(input bit v, input bit sh, input int f, input bit ui, input int a,
                          input int b, input int im, input int n, input int rd,
                          input bit sv, input bit rs);
        int r;
        bit co, oz, oc, osz, osc, longshift;
        ref_calc(sh, 3'(f), a, ui ? im : b, n, m_c, r, co);
        longshift = v && sh && (n > 0);
        valid_i = v; is_shift_i = sh; func_i = 3'(f); use_imm_i = ui;
        rs_val_i = 8'(a); rs2_val_i = 8'(b); imm_i = 8'(im); count_i = 3'(n);
        rd_i = 3'(rd); flag_save_i = sv; flag_restore_i = rs;
        oz = m_z; oc = m_c; osz = s_z; osc = s_c;
        if (sv) begin s_z = oz; s_c = oc; end
        if (v && !longshift) begin m_z = (r == 0); m_c = co; end
        if (rs) begin m_z = osz; m_c = osc; end
        if (longshift) begin
            for (int k = 1; k <= n; k++) begin
                @(negedge clkg);
                flag_save_i = 0; flag_restore_i = 0;
                chk("busy_hi", busy_o, 1);
                chk("we_busy", we_o, 0);
                chk("z_busy", z_o, m_z);
                // junk op offered while busy must be dropped
                valid_i = 1; is_shift_i = 1'($urandom); func_i = 3'($urandom);
                rs_val_i = 8'($urandom); rs2_val_i = 8'($urandom); count_i = 3'($urandom);
                rd_i = 3'($urandom);
            end
            m_z = (r == 0); m_c = co;
        end
        @(negedge clkg);
        chk("busy", busy_o, 0);
        chk("we", we_o, (v && rd != 0) ? 1 : 0);
        if (v && rd != 0) begin
            chk("rd", rd_o, rd);
            chk("dat", dat_o, r);
        end
        chk("z", z_o, m_z);
        chk("c", c_o, m_c);
        valid_i = 0; flag_save_i = 0; flag_restore_i = 0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #12;
        chk("rst_we", we_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_zc", {z_o, c_o}, 0);
        @(negedge clkg);
        rst = 0;
        idle(1);

        // add then back-to-back addc with immediate
        run_op(1, 0, 0, 0, 'hF0, 'h20, 0, 0, 3, 0, 0);
        run_op(1, 0, 1, 1, 'h01, 'h55, 'h01, 0, 4, 0, 0);
        idle(1);
        run_op(1, 0, 2, 0, 'h05, 'h05, 0, 0, 5, 0, 0);
        run_op(1, 0, 0, 0, 'hF0, 'h20, 0, 0, 1, 0, 0);
        run_op(1, 0, 3, 0, 'h00, 'h00, 0, 0, 6, 0, 0);
        idle(1);
        // serial shifts, count 0 pass-through, illegal shift func
        run_op(1, 1, 2, 0, 'h81, 0, 0, 3, 2, 0, 0);
        run_op(1, 1, 1, 0, 'h01, 0, 0, 1, 7, 0, 0);
        run_op(1, 1, 3, 0, 'h5A, 0, 0, 0, 1, 0, 0);
        run_op(1, 1, 6, 0, 'hC3, 0, 0, 7, 1, 0, 0);
        // r0 write suppressed
        run_op(1, 0, 4, 0, 'hFF, 'h0F, 0, 0, 0, 0, 0);
        idle(1);
        // save Z=1,C=1, clobber flags, restore wins over a concurrent add
        run_op(1, 0, 0, 0, 'h80, 'h80, 0, 0, 1, 0, 0);
        run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_op(1, 0, 6, 0, 'h01, 'h00, 0, 0, 2, 0, 0);
        run_op(1, 0, 0, 0, 'h01, 'h01, 0, 0, 3, 0, 1);
        // save+restore together swaps
        run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        for (int i = 0; i < 200; i++) begin
            run_op(1, ($urandom_range(0, 2) == 0), $urandom_range(0, 7), 1'($urandom),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        // reset asserted mid-shift aborts without write-back
        run_op(1, 0, 0, 0, 'hF0, 'h20, 0, 0, 3, 0, 0);
        valid_i = 1; is_shift_i = 1; func_i = 3'd2; rs_val_i = 8'h81; count_i = 3'd5; rd_i = 3'd4;
        @(negedge clkg);
        valid_i = 0;
        @(negedge clkg);
        chk("busy_pre_rst", busy_o, 1);
        #2 rst = 1;
        #1;
        chk("rst_busy_mid", busy_o, 0);
        chk("rst_we_mid", we_o, 0);
        chk("rst_dat_mid", dat_o, 0);
        chk("rst_zc_mid", {z_o, c_o}, 0);
        @(negedge clkg);
        rst = 0;
        m_z = 0; m_c = 0; s_z = 0; s_c = 0;
        idle(7);
        run_op(1, 0, 5, 0, 'h30, 'h03, 0, 0, 6, 0, 0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
